// File: rtl/brq_lsu_pkg.sv
// Shared LSU types: request size and FSM state enums, DCCM lane codes
// and the lane-code encoder used by the DCCM front-end.
package brq_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'd0,
    LSU_HALF = 2'd1,
    LSU_WORD = 2'd2
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] BE_B0 = 3'b000;
  localparam logic [2:0] BE_B1 = 3'b001;
  localparam logic [2:0] BE_B2 = 3'b010;
  localparam logic [2:0] BE_B3 = 3'b011;
  localparam logic [2:0] BE_HU = 3'b100;
  localparam logic [2:0] BE_HL = 3'b101;
  localparam logic [2:0] BE_W  = 3'b110;

  // Byte lane = addr[1:0]; half picks upper/lower by addr[1].
  function automatic logic [2:0] lane_code(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic [2:0] code;
    code = BE_W;
    unique case (1'b1)
      size == LSU_BYTE: code = {1'b0, lo};
      size == LSU_HALF: code = lo[1] ? BE_HU : BE_HL;
      default:          code = BE_W;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/brq_lsu_load_align.sv
// Load data aligner: picks byte/half lane from a 32-bit word by addr[1:0]
// and sign/zero-extends. Ports: rdata, addr_lo, size, sext -> data.
module brq_lsu_load_align
  import brq_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[{addr_lo, 3'b000} +: 8];
    h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data = rdata;
    unique case (1'b1)
      size == LSU_BYTE: data = {{24{sext & b[7]}}, b};
      size == LSU_HALF: data = {{16{sext & h[15]}}, h};
      default:          data = rdata;
    endcase
  end

endmodule

// File: rtl/brq_lsu_dccm_ctrl.sv
// LSU front-end to the DCCM: req handshake in, one DCCM access, registered
// resp out (rdata/err). Ports: lsu_req_*, lsu_resp_*, dccm_*.
module brq_lsu_dccm_ctrl
  import brq_lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] DCCM_BASE  = 32'h0002_0000
) (
  input  logic                  brq_clk,
  input  logic                  brq_rst_n,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_req_we,
  input  logic [1:0]            lsu_req_size,
  input  logic                  lsu_req_sext,
  input  logic [31:0]           lsu_req_addr,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_WIDTH-1:0] lsu_resp_rdata,
  output logic                  lsu_resp_err,
  output logic [2:0]            dccm_byte_enable,
  output logic [ADDR_WIDTH-1:0] dccm_address,
  output logic [DATA_WIDTH-1:0] dccm_data_in,
  output logic                  dccm_write_enable,
  output logic                  dccm_read_enable,
  input  logic [DATA_WIDTH-1:0] dccm_data_out
);

  localparam int unsigned AW2 = ADDR_WIDTH + 2;

  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  sext_q, sext_d;
  logic [AW2-1:0]        addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  resp_valid_q, resp_valid_d;

  logic                  mis, oor, bad_sz, req_err;
  logic                  in_access;
  logic [31:0]           load_data;

  assign bad_sz  = lsu_req_size == 2'd3;
  assign mis     = (lsu_req_size == LSU_HALF && lsu_req_addr[0])
                || (lsu_req_size == LSU_WORD && |lsu_req_addr[1:0]);
  assign oor     = lsu_req_addr[31:AW2] != DCCM_BASE[31:AW2];
  assign req_err = bad_sz | mis | oor;

  brq_lsu_load_align u_align (
    .rdata   (dccm_data_out),
    .addr_lo (addr_q[1:0]),
    .size    (size_q),
    .sext    (sext_q),
    .data    (load_data)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    sext_d       = sext_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    resp_valid_d = resp_valid_q;
    unique case (state_q)
      IDLE: begin
        if (lsu_req_valid) begin
          we_d    = lsu_req_we;
          size_d  = lsu_req_size;
          sext_d  = lsu_req_sext;
          addr_d  = lsu_req_addr[AW2-1:0];
          wdata_d = lsu_req_wdata;
          if (req_err) begin
            // Rejected requests skip the DCCM entirely.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            rdata_d      = '0;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        err_d        = 1'b0;
        rdata_d      = we_q ? '0 : load_data;
      end
      RESP: begin
        if (lsu_resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          rdata_d      = '0;
          err_d        = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge brq_clk or negedge brq_rst_n) begin
    if (!brq_rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      sext_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Strobes decode straight from the state flop so an async reset
  // kills an in-flight write before the next edge.
  assign in_access         = state_q == ACCESS;
  assign dccm_write_enable = in_access & we_q;
  assign dccm_read_enable  = in_access & ~we_q;
  assign dccm_byte_enable  = in_access ? lane_code(size_q, addr_q[1:0]) : BE_W;
  assign dccm_address      = in_access ? addr_q[AW2-1:2] : '0;
  assign dccm_data_in      = in_access ? wdata_q : '0;

  assign lsu_req_ready  = state_q == IDLE;
  assign lsu_resp_valid = resp_valid_q;
  assign lsu_resp_rdata = rdata_q;
  assign lsu_resp_err   = err_q;

endmodule
